// File: rtl/pipe_stage_buffer.sv
// Parametrised pipeline-stage register: valid/ready handshake, bubble collapsing,
// flush, and an optional input skid entry that gives a flop-driven in_ready.
module pipe_stage_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned STAGES = 1,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = $clog2(STAGES + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  level
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] rdy;
  logic [DATA_W-1:0] d [STAGES];
  logic              sv;
  logic [DATA_W-1:0] sd;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;

  // Ready ripples from the tail; an empty slice never blocks upstream.
  always_comb begin : ready_chain
    logic r;
    rdy = '0;
    r = ~v[STAGES-1] | out_ready;
    rdy[STAGES-1] = r;
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      r = ~v[i] | r;
      rdy[i] = r;
    end
  end

  // A held skid entry always takes precedence over the live input.
  always_comb begin
    src_valid = in_valid;
    src_data  = in_data;
    if (sv) begin
      src_valid = 1'b1;
      src_data  = sd;
    end
  end

  if (SKID != 0) begin : g_skid
    logic in_xfer;

    assign in_ready = ~sv & ~flush;
    assign in_xfer  = in_valid & in_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        sv <= 1'b0;
        sd <= '0;
      end else begin
        if (flush) begin
          sv <= 1'b0;
        end else if (in_xfer & ~rdy[0]) begin
          sv <= 1'b1;
        end else if (sv & rdy[0]) begin
          sv <= 1'b0;
        end
        if (in_xfer & ~rdy[0]) begin
          sd <= in_data;
        end
      end
    end
  end else begin : g_no_skid
    assign in_ready = rdy[0] & ~flush;
    assign sv       = 1'b0;
    assign sd       = '0;
  end

  // Slice registers; flush clears valids but leaves data stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        d[i] <= '0;
      end
    end else begin
      if (rdy[0]) begin
        v[0] <= src_valid;
        if (src_valid) begin
          d[0] <= src_data;
        end
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        if (rdy[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            d[i] <= d[i-1];
          end
        end
      end
      if (flush) begin
        v <= '0;
      end
    end
  end

  always_comb begin
    level = CNT_W'(sv);
    for (int i = 0; i < int'(STAGES); i++) begin
      level = level + CNT_W'(v[i]);
    end
  end

  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer across four parameter sets sharing one clock/reset.
module tb_pipe_stage_buffer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // A: STAGES=3 SKID=1
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_in_data, a_out_data;
  logic [2:0]  a_level;
  // B: STAGES=2 SKID=1
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_data, b_out_data;
  logic [1:0]  b_level;
  // C: STAGES=4 SKID=1
  logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [15:0] c_in_data, c_out_data;
  logic [2:0]  c_level;
  // D: STAGES=1 SKID=0
  logic        d_flush, d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [15:0] d_in_data, d_out_data;
  logic [1:0]  d_level;

  pipe_stage_buffer #(.DATA_W(16), .STAGES(3), .SKID(1)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .level(a_level));

  pipe_stage_buffer #(.DATA_W(16), .STAGES(2), .SKID(1)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .level(b_level));

  pipe_stage_buffer #(.DATA_W(16), .STAGES(4), .SKID(1)) u_c (
    .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .level(c_level));

  pipe_stage_buffer #(.DATA_W(16), .STAGES(1), .SKID(0)) u_d (
    .clk(clk), .rst(rst), .flush(d_flush), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_data(d_out_data), .level(d_level));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not complete");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_out_data, a_level, a_in_ready} !== {1'b0, 16'h0000, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_init_a got=%h want=%h", {a_out_valid, a_out_data, a_level, a_in_ready},
               {1'b0, 16'h0000, 3'd0, 1'b1});
    end
    checks++;
    if ({b_out_valid, b_out_data, b_level, b_in_ready} !== {1'b0, 16'h0000, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_init_b got=%h want=%h", {b_out_valid, b_out_data, b_level, b_in_ready},
               {1'b0, 16'h0000, 2'd0, 1'b1});
    end
    checks++;
    if ({c_out_valid, c_out_data, c_level, c_in_ready} !== {1'b0, 16'h0000, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_init_c got=%h want=%h", {c_out_valid, c_out_data, c_level, c_in_ready},
               {1'b0, 16'h0000, 3'd0, 1'b1});
    end
    checks++;
    if ({d_out_valid, d_out_data, d_level, d_in_ready} !== {1'b0, 16'h0000, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_init_d got=%h want=%h", {d_out_valid, d_out_data, d_level, d_in_ready},
               {1'b0, 16'h0000, 2'd0, 1'b1});
    end
    tick();
    // fill A to three entries, then reset for two cycles mid-stream
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_in_data = 16'h0100 + 16'(k);
      tick();
    end
    a_in_data = 16'h0103;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (a_level !== 3'd3) begin
      failures++;
      $display("FAIL reset_prefill_level got=%0d want=3", a_level);
    end
    tick();
    tick();
    rst = 1'b0;
    a_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_out_data, a_level, a_in_ready} !== {1'b0, 16'h0000, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_midstream got=%h want=%h", {a_out_valid, a_out_data, a_level, a_in_ready},
               {1'b0, 16'h0000, 3'd0, 1'b1});
    end
    tick();
  endtask

  task automatic test_streaming();
    logic exp_v;
    a_out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      a_in_valid = (c < 8);
      a_in_data  = 16'(c + 1);
      @(negedge clk);
      if (c < 8) begin
        checks++;
        if (a_in_ready !== 1'b1) begin
          failures++;
          $display("FAIL stream_in_ready cycle=%0d got=%b want=1", c, a_in_ready);
        end
      end
      exp_v = (c >= 3) && (c < 11);
      checks++;
      if (a_out_valid !== exp_v) begin
        failures++;
        $display("FAIL stream_out_valid cycle=%0d got=%b want=%b", c, a_out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (a_out_data !== 16'(c - 2)) begin
          failures++;
          $display("FAIL stream_out_data cycle=%0d got=%h want=%h", c, a_out_data, 16'(c - 2));
        end
      end
      if (c == 5) begin
        checks++;
        if (a_level !== 3'd3) begin
          failures++;
          $display("FAIL stream_level got=%0d want=3", a_level);
        end
      end
      tick();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int idx;
    int got;
    idx = 0;
    got = 0;
    b_out_ready = 1'b0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (c == 5) b_out_ready = 1'b1;
      b_in_valid = (idx < 6);
      b_in_data  = 16'h00A0 + 16'(idx);
      @(negedge clk);
      if (c < 3) begin
        checks++;
        if (b_in_ready !== 1'b1) begin
          failures++;
          $display("FAIL bp_accept cycle=%0d got=%b want=1", c, b_in_ready);
        end
      end
      if (c >= 3 && c <= 5) begin
        checks++;
        if (b_in_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_full_ready cycle=%0d got=%b want=0", c, b_in_ready);
        end
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (b_level !== 2'd3) begin
          failures++;
          $display("FAIL bp_level cycle=%0d got=%0d want=3", c, b_level);
        end
      end
      if (c == 6) begin
        checks++;
        if (b_in_ready !== 1'b1) begin
          failures++;
          $display("FAIL bp_resume_ready got=%b want=1", b_in_ready);
        end
      end
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (b_out_data !== 16'h00A0 + 16'(got)) begin
          failures++;
          $display("FAIL bp_order idx=%0d got=%h want=%h", got, b_out_data, 16'h00A0 + 16'(got));
        end
        got++;
      end
      if (b_in_valid && b_in_ready) idx++;
      tick();
    end
    b_in_valid = 1'b0;
    checks++;
    if (got != 6) begin
      failures++;
      $display("FAIL bp_drained got=%0d want=6", got);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({b_out_valid, b_level} !== {1'b0, 2'd0}) begin
      failures++;
      $display("FAIL bp_no_duplicate got=%h want=0", {b_out_valid, b_level});
    end
    tick();
    b_out_ready = 1'b0;
  endtask

  task automatic test_bubble_collapse();
    c_out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      c_in_valid = (c == 0) || (c == 3);
      c_in_data  = (c == 0) ? 16'hBEEF : 16'hCAFE;
      @(negedge clk);
      tick();
    end
    c_in_valid  = 1'b0;
    c_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({c_level, c_out_valid, c_out_data} !== {3'd2, 1'b1, 16'hBEEF}) begin
      failures++;
      $display("FAIL bubble_head got=%h want=%h", {c_level, c_out_valid, c_out_data},
               {3'd2, 1'b1, 16'hBEEF});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({c_out_valid, c_out_data} !== {1'b1, 16'hCAFE}) begin
      failures++;
      $display("FAIL bubble_second got=%h want=%h", {c_out_valid, c_out_data}, {1'b1, 16'hCAFE});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({c_out_valid, c_level} !== {1'b0, 3'd0}) begin
      failures++;
      $display("FAIL bubble_empty got=%h want=0", {c_out_valid, c_level});
    end
    tick();
    c_out_ready = 1'b0;
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_in_data = 16'h0D01 + 16'(k);
      tick();
    end
    a_in_data   = 16'h5555;
    a_out_ready = 1'b1;
    a_flush     = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_level, a_out_valid, a_out_data} !== {3'd3, 1'b1, 16'h0D01}) begin
      failures++;
      $display("FAIL flush_head got=%h want=%h", {a_level, a_out_valid, a_out_data},
               {3'd3, 1'b1, 16'h0D01});
    end
    checks++;
    if (a_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_in_ready got=%b want=0", a_in_ready);
    end
    tick();
    a_flush     = 1'b0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_level, a_out_valid, a_in_ready} !== {3'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL flush_after got=%h want=%h", {a_level, a_out_valid, a_in_ready},
               {3'd0, 1'b0, 1'b1});
    end
    tick();
  endtask

  task automatic test_simultaneous();
    d_out_ready = 1'b0;
    d_in_valid  = 1'b1;
    d_in_data   = 16'h1111;
    @(negedge clk);
    checks++;
    if (d_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_first_ready got=%b want=1", d_in_ready);
    end
    tick();
    d_in_data = 16'h2222;
    @(negedge clk);
    checks++;
    if ({d_in_ready, d_level, d_out_data} !== {1'b0, 2'd1, 16'h1111}) begin
      failures++;
      $display("FAIL simul_full_block got=%h want=%h", {d_in_ready, d_level, d_out_data},
               {1'b0, 2'd1, 16'h1111});
    end
    tick();
    d_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({d_in_ready, d_out_valid, d_out_data} !== {1'b1, 1'b1, 16'h1111}) begin
      failures++;
      $display("FAIL simul_pass_through got=%h want=%h", {d_in_ready, d_out_valid, d_out_data},
               {1'b1, 1'b1, 16'h1111});
    end
    tick();
    d_in_valid  = 1'b0;
    d_out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_level, d_out_valid, d_out_data} !== {2'd1, 1'b1, 16'h2222}) begin
      failures++;
      $display("FAIL simul_new_entry got=%h want=%h", {d_level, d_out_valid, d_out_data},
               {2'd1, 1'b1, 16'h2222});
    end
    // flush gates in_ready combinationally even when out_ready would open it
    d_out_ready = 1'b1;
    d_flush     = 1'b1;
    #1;
    checks++;
    if (d_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL simul_flush_gate got=%b want=0", d_in_ready);
    end
    tick();
    d_flush     = 1'b0;
    d_out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_level, d_out_valid, d_in_ready} !== {2'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL simul_after_flush got=%h want=%h", {d_level, d_out_valid, d_in_ready},
               {2'd0, 1'b0, 1'b1});
    end
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
    d_flush = 1'b0; d_in_valid = 1'b0; d_in_data = '0; d_out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble_collapse();
    test_flush();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
